// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the keypad debouncer
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

  localparam int KEY_W = 4;
  localparam int DEBOUNCE_DEFAULT = 41600;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - single-key debouncer with one-hot, index and press/release strobes
module button_debouncer
  import calc_pkg::*;
#(
  parameter int NUM_KEYS        = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n,
  input  logic [NUM_KEYS-1:0]         button_i,
  output logic [NUM_KEYS-1:0]         buttons_o,
  output logic [$clog2(NUM_KEYS)-1:0] key_code_o,
  output logic                        press_o,
  output logic                        release_o,
  output logic                        busy_o
);

  localparam int CODE_W = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  debounce_state_t     state;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] cand;
  logic [CNT_W-1:0]    cnt;

  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  sync_2ff #(.WIDTH(NUM_KEYS)) u_sync (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .d      (button_i),
    .q      (sync)
  );

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      buttons_o  <= '0;
      key_code_o <= '0;
      press_o    <= 1'b0;
      release_o  <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      case (state)
        IDLE: begin
          if (is_one_hot(sync)) begin
            cand  <= sync;
            cnt   <= '0;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (sync != cand) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state      <= HELD;
            press_o    <= 1'b1;
            buttons_o  <= cand;
            key_code_o <= key_index(cand);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (sync != cand) begin
            cnt   <= '0;
            state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          // Release is only accepted once every key is up; any other chord restarts the wait.
          if (sync == cand) begin
            state <= HELD;
          end else if (sync == '0) begin
            if (cnt == CNT_LAST) begin
              state      <= IDLE;
              release_o  <= 1'b1;
              buttons_o  <= '0;
              key_code_o <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic        clk_i;
  logic        reset_n;
  logic [15:0] button_i;
  logic [15:0] buttons_o;
  logic [3:0]  key_code_o;
  logic        press_o;
  logic        release_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;
  int press_cnt = 0;
  int rel_cnt = 0;
  int both_cnt = 0;
  int p0;
  int r0;

  button_debouncer #(
    .NUM_KEYS       (16),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .button_i  (button_i),
    .buttons_o (buttons_o),
    .key_code_o(key_code_o),
    .press_o   (press_o),
    .release_o (release_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(negedge clk_i) begin
    if (press_o) press_cnt++;
    if (release_o) rel_cnt++;
    if (press_o && release_o) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    reset_n  = 1'b0;
    button_i = 16'h0000;
    step(3);
    chk("rst_buttons", 32'(buttons_o), 32'h0);
    chk("rst_code", 32'(key_code_o), 32'h0);
    chk("rst_press", 32'(press_o), 32'h0);
    chk("rst_release", 32'(release_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    reset_n = 1'b1;
    step(2);

    // Clean press of key 5: press after the 7th edge.
    button_i = 16'h0020;
    step(6);
    chk("t1_press_early", 32'(press_o), 32'h0);
    chk("t1_busy_wait", 32'(busy_o), 32'h1);
    step(1);
    chk("t1_press", 32'(press_o), 32'h1);
    chk("t1_buttons", 32'(buttons_o), 32'h0020);
    chk("t1_code", 32'(key_code_o), 32'h5);
    chk("t1_busy", 32'(busy_o), 32'h1);
    step(1);
    chk("t1_press_one", 32'(press_o), 32'h0);
    chk("t1_buttons_hold", 32'(buttons_o), 32'h0020);

    // Second key added while held: no press, release only after all keys up.
    p0 = press_cnt;
    button_i = 16'h0021;
    step(10);
    chk("t3_no_press", 32'(press_cnt), 32'(p0));
    chk("t3_buttons", 32'(buttons_o), 32'h0020);
    chk("t3_busy", 32'(busy_o), 32'h1);
    button_i = 16'h0000;
    step(5);
    chk("t3_rel_early", 32'(release_o), 32'h0);
    chk("t3_buttons_still", 32'(buttons_o), 32'h0020);
    step(1);
    chk("t3_release", 32'(release_o), 32'h1);
    chk("t3_buttons_clr", 32'(buttons_o), 32'h0);
    chk("t3_code_clr", 32'(key_code_o), 32'h0);
    chk("t3_busy_clr", 32'(busy_o), 32'h0);
    step(1);
    chk("t3_release_one", 32'(release_o), 32'h0);
    step(3);

    // Short drop while held returns to HELD without a release.
    button_i = 16'h0020;
    step(7);
    chk("t4_press", 32'(press_o), 32'h1);
    r0 = rel_cnt;
    button_i = 16'h0000;
    step(2);
    button_i = 16'h0020;
    step(10);
    chk("t4_no_release", 32'(rel_cnt), 32'(r0));
    chk("t4_buttons", 32'(buttons_o), 32'h0020);
    chk("t4_busy", 32'(busy_o), 32'h1);
    button_i = 16'h0000;
    step(6);
    chk("t4_rel_early", 32'(release_o), 32'h0);
    step(1);
    chk("t4_release", 32'(release_o), 32'h1);
    chk("t4_buttons_clr", 32'(buttons_o), 32'h0);
    step(4);

    // Bouncing bit 3 for 20 cycles, then held.
    p0 = press_cnt;
    for (int i = 0; i < 10; i++) begin
      button_i = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      step(2);
    end
    chk("t2_no_bounce_press", 32'(press_cnt), 32'(p0));
    button_i = 16'h0008;
    step(6);
    chk("t2_press_early", 32'(press_o), 32'h0);
    chk("t2_no_press_yet", 32'(press_cnt), 32'(p0));
    step(1);
    chk("t2_press", 32'(press_o), 32'h1);
    chk("t2_code", 32'(key_code_o), 32'h3);
    chk("t2_buttons", 32'(buttons_o), 32'h0008);
    step(1);
    chk("t2_one_press", 32'(press_cnt), 32'(p0 + 1));
    button_i = 16'h0000;
    step(8);
    chk("t2_idle", 32'(busy_o), 32'h0);
    chk("t2_clr", 32'(buttons_o), 32'h0);

    // Multi-hot input never starts a debounce.
    p0 = press_cnt;
    r0 = rel_cnt;
    button_i = 16'h0011;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("t5_busy", 32'(busy_o), 32'h0);
    end
    chk("t5_no_press", 32'(press_cnt), 32'(p0));
    chk("t5_no_release", 32'(rel_cnt), 32'(r0));
    chk("t5_buttons", 32'(buttons_o), 32'h0);
    button_i = 16'h0000;
    step(4);

    // Reset in the middle of PRESS_WAIT clears outputs at once.
    button_i = 16'h0020;
    step(4);
    chk("t6_pw_busy", 32'(busy_o), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_pw_busy_rst", 32'(busy_o), 32'h0);
    chk("t6_pw_buttons_rst", 32'(buttons_o), 32'h0);
    chk("t6_pw_press_rst", 32'(press_o), 32'h0);
    step(2);
    p0 = press_cnt;
    r0 = rel_cnt;
    reset_n = 1'b1;
    step(6);
    chk("t6_no_strobe", 32'(press_cnt), 32'(p0));
    step(1);
    chk("t6_fresh_press", 32'(press_o), 32'h1);
    chk("t6_fresh_code", 32'(key_code_o), 32'h5);
    step(3);

    // Reset while HELD.
    #2 reset_n = 1'b0;
    #1;
    chk("t6_h_buttons_rst", 32'(buttons_o), 32'h0);
    chk("t6_h_code_rst", 32'(key_code_o), 32'h0);
    chk("t6_h_busy_rst", 32'(busy_o), 32'h0);
    chk("t6_h_release_rst", 32'(release_o), 32'h0);
    button_i = 16'h0000;
    step(2);
    p0 = press_cnt;
    reset_n = 1'b1;
    step(10);
    chk("t6_h_no_press", 32'(press_cnt), 32'(p0));
    chk("t6_h_no_release", 32'(rel_cnt), 32'(r0));
    chk("t6_h_idle", 32'(busy_o), 32'h0);

    chk("no_overlap", 32'(both_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Conditions the raw 16-bit keypad vector before it reaches Button_Decoder. Each key input is synchronised into clk_i, and only a single key held stable for DEBOUNCE_CYCLES is accepted. The block then emits a clean one-hot vector, a 4-bit key index, and single-cycle press/release strobes. Button_Verify and ram can consume these strobes instead of raw levels, which are bouncy and multi-cycle.

Parameters:
NUM_KEYS, 16, number of key inputs; key_code width is $clog2(NUM_KEYS).
DEBOUNCE_CYCLES, 41600, stable cycles required to accept a press or release (20 ms at the 2.08 MHz OSCH clock); legal range 2 to 2^CNT_W-1.
CNT_W, 16, width of the shared stability counter.

Ports:
clk_i  input  1  system clock (OSCH, 2.08 MHz).
reset_n  input  1  asynchronous, active-low reset.
button_i  input  NUM_KEYS  raw keys, active-high, asynchronous to clk_i.
buttons_o  output  NUM_KEYS  debounced key; one-hot while a key is accepted, otherwise all zero; drives Button_Decoder.buttons.
key_code_o  output  4  index of the accepted key; 0 when none is accepted.
press_o  output  1  one-cycle strobe when a press is accepted.
release_o  output  1  one-cycle strobe when a release is accepted.
busy_o  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-low, reset_n.
- Reset (asserted at any time, including mid-debounce):
  - state returns to IDLE;
  - both synchroniser stages, cand, and cnt clear to 0;
  - all outputs clear to 0.
  - No strobe is generated on reset or on reset release.
- Synchroniser: 2-flop per bit; sync = second stage. All decisions use sync only.
- State register uses states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - if sync is exactly one-hot: cand <= sync, cnt <= 0, go to PRESS_WAIT;
  - zero or multi-hot: stay in IDLE.
- PRESS_WAIT:
  - if sync != cand: go to IDLE with no output, treated as bounce;
  - else if cnt == DEBOUNCE_CYCLES-1: go to HELD, with press_o=1 for one cycle, buttons_o<=cand, key_code_o<=index(cand);
  - else cnt++.
- HELD:
  - buttons_o and key_code_o are held;
  - if sync != cand (the key is released or another key is added): cnt <= 0, go to RELEASE_WAIT.
- RELEASE_WAIT:
  - buttons_o and key_code_o are still held;
  - sync == cand: return to HELD, no strobe;
  - sync == 0: if cnt == DEBOUNCE_CYCLES-1, go to IDLE with release_o=1 for one cycle and buttons_o, key_code_o cleared in the same cycle; otherwise cnt++;
  - any other nonzero value: cnt <= 0 and stay. Release requires all keys up.
- Latency: a clean edge first sampled at edge k gives press_o high after edge k+DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)th edge. Release is symmetric.
- press_o and release_o are registered outputs. They are never high together and never high on consecutive cycles.
- A second key pressed while one is held never produces a press. The user must release all keys first.
- cnt saturates logically via the compare, so it never wraps.

Decomposition:
- Shared package calc_pkg holds:
  - typedef enum logic [1:0] debounce_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - localparam KEY_W = 4;
  - localparam DEBOUNCE_DEFAULT = 41600.
- One sub-module, sync_2ff: a parameterised-width 2-flop synchroniser clocked by clk_i and cleared by reset_n.
- One-hot check and index encoding stay as combinational functions inside button_debouncer.

Test Plan:
- DEBOUNCE_CYCLES=4; hold button_i=16'h0020 from edge 0 -> press_o high for exactly one cycle after edge 6, buttons_o=16'h0020, key_code_o=5, busy_o=1.
- Toggle bit 3 every 2 cycles for 20 cycles, then hold high -> no strobe during the toggling; exactly one press_o, key_code_o=3, DEBOUNCE_CYCLES+3 edges after the last toggle.
- Key 5 held and accepted; assert button_i=16'h0021 -> no press_o; buttons_o stays 16'h0020 until all keys are zero for 4 cycles, then release_o pulses and buttons_o=0.
- Key 5 held; drop to 0 for 2 cycles, then back to 16'h0020 -> no release_o; state returns to HELD.
- button_i=16'h0011 held for 50 cycles -> busy_o stays 0, no strobes, buttons_o=0.
- Assert reset_n=0 in the middle of PRESS_WAIT, then in HELD -> all outputs 0 immediately (asynchronously); after release, no strobe until a fresh 4-cycle-stable press.
